// File: rtl/tc_ram_arbiter.sv
// Two-port arbiter/sequencer sharing one TC_FastRam: registered command stage, registered read response.
// Optional macro TC_RAM_ARB_ROUND_ROBIN_EN selects round-robin tie-break; default is fixed port-0 priority.
module tc_ram_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  input  logic                  req0_write,
  input  logic                  req0_lock,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic                  req1_write,
  input  logic                  req1_lock,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  req1_ready,
  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_data,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_data,
  output logic                  ram_load,
  output logic                  ram_save,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_in,
  input  logic [DATA_WIDTH-1:0] ram_out
);

  // Handshake: a command transfers when reqN_valid && reqN_ready; ready is at most one-hot
  // and never depends on downstream state, since an accepted command always issues.
  logic                  owner_valid_q, owner_valid_d;
  logic                  owner_q, owner_d;
  logic                  s1_valid_q, s1_valid_d;
  logic                  s1_write_q, s1_write_d;
  logic                  s1_port_q, s1_port_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  rsp0_valid_q, rsp0_valid_d;
  logic                  rsp1_valid_q, rsp1_valid_d;
  logic [DATA_WIDTH-1:0] rsp0_data_q, rsp0_data_d;
  logic [DATA_WIDTH-1:0] rsp1_data_q, rsp1_data_d;
  logic                  tie_pick1;
  logic                  acc0, acc1;
  logic                  s1_read;

`ifdef TC_RAM_ARB_ROUND_ROBIN_EN
  logic last_q, last_d;

  // On a tie the port that was not granted last wins.
  assign tie_pick1 = ~last_q;

  always_comb begin
    last_d = last_q;
    if (acc0)      last_d = 1'b0;
    else if (acc1) last_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) last_q <= 1'b1;
    else     last_q <= last_d;
  end
`else
  assign tie_pick1 = 1'b0;
`endif

  always_comb begin
    acc0 = 1'b0;
    acc1 = 1'b0;
    if (!rst) begin
      if (owner_valid_q) begin
        acc0 = req0_valid & ~owner_q;
        acc1 = req1_valid &  owner_q;
      end else begin
        acc1 = req1_valid & (~req0_valid | tie_pick1);
        acc0 = req0_valid & ~acc1;
      end
    end
  end

  assign req0_ready = acc0;
  assign req1_ready = acc1;

  always_comb begin
    owner_valid_d = owner_valid_q;
    owner_d       = owner_q;
    if (acc0) begin
      owner_valid_d = req0_lock;
      owner_d       = 1'b0;
    end else if (acc1) begin
      owner_valid_d = req1_lock;
      owner_d       = 1'b1;
    end
  end

  // Stage 1: address and write data hold their last value when idle.
  always_comb begin
    s1_valid_d = acc0 | acc1;
    s1_write_d = acc1 ? req1_write : req0_write;
    s1_port_d  = acc1;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if (acc1) begin
      addr_d  = req1_addr;
      wdata_d = req1_wdata;
    end else if (acc0) begin
      addr_d  = req0_addr;
      wdata_d = req0_wdata;
    end
  end

  assign s1_read = s1_valid_q & ~s1_write_q;

  always_comb begin
    rsp0_valid_d = s1_read & ~s1_port_q;
    rsp1_valid_d = s1_read &  s1_port_q;
    rsp0_data_d  = rsp0_valid_d ? ram_out : rsp0_data_q;
    rsp1_data_d  = rsp1_valid_d ? ram_out : rsp1_data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_valid_q <= 1'b0;
      owner_q       <= 1'b0;
      s1_valid_q    <= 1'b0;
      s1_write_q    <= 1'b0;
      s1_port_q     <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      rsp0_valid_q  <= 1'b0;
      rsp1_valid_q  <= 1'b0;
      rsp0_data_q   <= '0;
      rsp1_data_q   <= '0;
    end else begin
      owner_valid_q <= owner_valid_d;
      owner_q       <= owner_d;
      s1_valid_q    <= s1_valid_d;
      s1_write_q    <= s1_write_d;
      s1_port_q     <= s1_port_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      rsp0_valid_q  <= rsp0_valid_d;
      rsp1_valid_q  <= rsp1_valid_d;
      rsp0_data_q   <= rsp0_data_d;
      rsp1_data_q   <= rsp1_data_d;
    end
  end

  // Pins are masked during reset so an in-flight command never reaches the RAM.
  assign ram_load    = s1_read & ~rst;
  assign ram_save    = s1_valid_q & s1_write_q & ~rst;
  assign ram_address = addr_q;
  assign ram_in      = wdata_q;
  assign rsp0_valid  = rsp0_valid_q;
  assign rsp1_valid  = rsp1_valid_q;
  assign rsp0_data   = rsp0_data_q;
  assign rsp1_data   = rsp1_data_q;

endmodule

// File: doc/tc_ram_arbiter.md
# tc_ram_arbiter

Two-port arbiter and sequencer that shares one TC_FastRam instance between two independent requesters. It accepts at most one read or write command per cycle and drives the RAM's load/save/address/in pins from a registered command stage. It returns read data to the requester that issued the read. The block sits between CPU-side or DMA-side masters and a single TC_FastRam, and adds fixed, pipelined latency.

## Interface
- ADDR_WIDTH, 16, RAM address width
- DATA_WIDTH, 16, RAM data width
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- reqN_valid  in  1  (N=0,1) command present
- reqN_write  in  1  1 = write, 0 = read
- reqN_lock  in  1  keep exclusive grant after this command
- reqN_addr  in  ADDR_WIDTH  command address
- reqN_wdata  in  DATA_WIDTH  write data
- reqN_ready  out  1  command accepted this cycle (combinational from valid/lock/arbiter state)
- rspN_valid  out  1  read data valid, one-cycle pulse per read
- rspN_data  out  DATA_WIDTH  read data
- ram_load  out  1  to TC_FastRam load
- ram_save  out  1  to TC_FastRam save
- ram_address  out  ADDR_WIDTH  to TC_FastRam address
- ram_in  out  DATA_WIDTH  to TC_FastRam in
- ram_out  in  DATA_WIDTH  from TC_FastRam out; combinational read of ram_address while ram_load=1

## Operation
- A command is accepted when reqN_valid=1 and reqN_ready=1. At most one port is ready in any cycle. No back-pressure exists: an accepted command always issues.
- Stage 1 (command register): the accepted command is captured. In the next cycle ram_save=write, ram_load=~write, and address/in are taken from the register. When no command is accepted, ram_load=ram_save=0; address and in hold their last value.
- Stage 2 (response register): for a read, ram_out is captured into rspN_data of the issuing port, and rspN_valid=1 for exactly one cycle. Writes produce no response. rspN_data holds its value until the next read for that port.
- Grant selection, no lock owner:
  - Only one port valid: that port wins.
  - Both ports valid: the winner is chosen by the priority rule (see Configuration).
- Lock: when a command is accepted with lock=1, that port becomes owner. While an owner exists, the other port's ready is 0. Ownership clears when the owner has an accepted command with lock=0. An owner with valid=0 keeps ownership.
- Priority state records the last granted port. It updates only on acceptance.
- Hazards: commands are strictly in order. A read accepted in the cycle after a write to the same address returns the new data.

## Timing
- Reset values: reqN_ready=0 while rst=1; rspN_valid=0; rspN_data=0; ram_load=0; ram_save=0; ram_address=0; ram_in=0; no lock owner; last-granted=port 1, so port 0 wins the first tie.
- Accept at cycle t: RAM pins are driven in t+1, and a read response appears in t+2. Throughput is one command per cycle with back-to-back commands in any mix.
- Reset mid-operation: commands in flight in stage 1 or stage 2 are discarded. No rsp pulse is produced, no RAM write is issued in the cycle after rst, and the lock owner is cleared.
- A read on one port and a response on the other port can occur in the same cycle. Both rsp valids can never be 1 together.

## Configuration
- TC_RAM_ARB_ROUND_ROBIN_EN defined: on a tie, the port not granted last wins, so each port is guaranteed at most one cycle of wait per pending command when lock is unused.
- Not defined: fixed priority. Port 0 always wins a tie, and the last-granted state is not implemented.

## Test plan
- Single write/read: req0 write addr 0x0000, wdata 0x0001 at t. Expect ram_save=1 at t+1. Then req0 read addr 0x0000 at t+2. Expect ram_load=1 at t+3, and rsp0_valid=1 with rsp0_data=0x0001 at t+4.
- Tie arbitration: both ports read every cycle for 4 cycles, with port 1 holding 0x0002 at addr 0x0001. With the macro, grants are 0,1,0,1 and rsp1_data=0x0002. Without it, grants are 0,0,0,0 and rsp1_valid stays 0.
- Lock: req1 write lock=1 at addr 0x0005, then port 0 valid continuously. Expect req0_ready=0 until req1 issues a command with lock=0, then req0_ready=1 on the following cycle.
- Back-to-back pipeline: req0 write 0x1234 to 0x0010 at t, then read 0x0010 at t+1. Expect rsp0_data=0x1234 at t+3.
- Reset mid-flight: req0 read accepted at t, rst=1 at t+1. Expect rsp0_valid=0 and ram_load=0 at t+1..t+2, and all outputs at reset values.
- Idle: no valids for 10 cycles. Expect ram_load=ram_save=0 and rsp valids=0 throughout.
